branch_predictor: RTL and testbench

- Direct-mapped branch history table (BHT) plus branch target buffer (BTB) for the 5-stage RV32I pipeline.
- Fetch stage: combinational lookup on PCF gives a predicted next PC.
- Execute stage: compares the prediction carried down the pipe against the branch logic's resolved PCSrcE, flags mispredicts with a redirect PC, and trains the table.
- Keeps saturating branch and mispredict statistics counters.

---
 rtl/branch_predictor_pkg.sv | 25 ++
 rtl/branch_predictor_if.sv | 36 +++
 rtl/branch_predictor_sat_counter2.sv | 29 ++
 rtl/branch_predictor.sv | 120 ++++++++++++
 tb/tb_branch_predictor.sv | 204 ++++++++++++++++++++
 5 files changed

// File: rtl/branch_predictor_pkg.sv
// Shared types and PC slicing helpers for the branch predictor.
package branch_predictor_pkg;

    // Default table size: 2^4 = 16 entries.
    localparam int IDX_BITS_DEF = 4;

    // 2-bit direction counter encodings.
    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } ctr_t;

    // Table index of a PC: word address modulo the table size.
    function automatic logic [31:0] pc_idx(input logic [31:0] pc, input int idx_bits);
        return (pc >> 2) & ((32'd1 << idx_bits) - 32'd1);
    endfunction

    // Tag of a PC: all bits above the index.
    function automatic logic [31:0] pc_tag(input logic [31:0] pc, input int idx_bits);
        return pc >> (idx_bits + 2);
    endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-lookup and execute-resolve signals between the pipeline and the predictor.
interface branch_predictor_if;

    logic [31:0] PCF;
    logic        PredTakenF;
    logic [31:0] PredTargetF;
    logic [31:0] PCE;
    logic [31:0] PCPlus4E;
    logic [31:0] PCTargetE;
    logic        BranchE;
    logic        JumpE;
    logic        PCSrcE;
    logic        PredTakenE;
    logic [31:0] PredTargetE;
    logic        ValidE;
    logic        StallE;
    logic        MispredictE;
    logic [31:0] RedirectPCE;
    logic [31:0] BrCount;
    logic [31:0] MissCount;

    // Pipeline side
    modport master (
        output PCF, PCE, PCPlus4E, PCTargetE, BranchE, JumpE, PCSrcE,
               PredTakenE, PredTargetE, ValidE, StallE,
        input  PredTakenF, PredTargetF, MispredictE, RedirectPCE, BrCount, MissCount
    );

    // Predictor side
    modport slave (
        input  PCF, PCE, PCPlus4E, PCTargetE, BranchE, JumpE, PCSrcE,
               PredTakenE, PredTargetE, ValidE, StallE,
        output PredTakenF, PredTargetF, MispredictE, RedirectPCE, BrCount, MissCount
    );

endinterface

// File: rtl/branch_predictor_sat_counter2.sv
// 2-bit saturating up/down counter with parallel load; resets to weak-not-taken.
module sat_counter2
    import branch_predictor_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic up,
    input  logic load,
    input  ctr_t load_val,
    output ctr_t q
);

    // Load wins over count; counting stops at either end.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= WNT;
        end else if (load) begin
            q <= load_val;
        end else if (en) begin
            if (up && q != ST) begin
                q <= ctr_t'(q + 2'd1);
            end else if (!up && q != SNT) begin
                q <= ctr_t'(q - 2'd1);
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BHT + BTB: combinational fetch lookup, execute-stage
// mispredict detection, table training and saturating statistics.
module branch_predictor
    import branch_predictor_pkg::*;
#(
    parameter int IDX_BITS = IDX_BITS_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    branch_predictor_if.slave   bp
);

    localparam int TAG_BITS = 30 - IDX_BITS;
    localparam int ENTRIES  = 1 << IDX_BITS;

    logic                valid  [ENTRIES];
    logic [TAG_BITS-1:0] tag_q  [ENTRIES];
    logic [31:0]         tgt_q  [ENTRIES];
    logic                jmp_q  [ENTRIES];
    ctr_t                ctr    [ENTRIES];

    logic [IDX_BITS-1:0] idx_f, idx_e;
    logic [TAG_BITS-1:0] tag_f, tag_e;
    logic                hit_f, hit_e;
    logic                ctl_e, upd_e, mis_e;
    logic [31:0]         redir_e;
    logic [ENTRIES-1:0]  wr, inv;
    logic [31:0]         br_count, miss_count;

    assign idx_f = IDX_BITS'(pc_idx(bp.PCF, IDX_BITS));
    assign tag_f = TAG_BITS'(pc_tag(bp.PCF, IDX_BITS));
    assign idx_e = IDX_BITS'(pc_idx(bp.PCE, IDX_BITS));
    assign tag_e = TAG_BITS'(pc_tag(bp.PCE, IDX_BITS));

    assign ctl_e = bp.BranchE | bp.JumpE;
    // A held instruction trains exactly once, on the cycle it leaves Execute.
    assign upd_e = bp.ValidE & ~bp.StallE;

    // Fetch lookup sees the stored (pre-update) entry; no same-cycle bypass.
    always_comb begin
        hit_f          = valid[idx_f] && (tag_q[idx_f] == tag_f);
        bp.PredTakenF  = hit_f && (jmp_q[idx_f] || ctr[idx_f][1]);
        bp.PredTargetF = bp.PredTakenF ? tgt_q[idx_f] : bp.PCF + 32'd4;
    end

    // Resolve: compare the carried prediction with the actual outcome.
    always_comb begin
        hit_e   = valid[idx_e] && (tag_q[idx_e] == tag_e);
        mis_e   = 1'b0;
        redir_e = bp.PCPlus4E;
        if (bp.ValidE) begin
            if (ctl_e && bp.PCSrcE) begin
                redir_e = bp.PCTargetE;
                mis_e   = !bp.PredTakenE || (bp.PredTargetE != bp.PCTargetE);
            end else begin
                // Not-taken branch, or a non-control op carrying a stale prediction.
                mis_e = bp.PredTakenE;
            end
        end
    end

    assign bp.MispredictE = mis_e;
    assign bp.RedirectPCE = redir_e;

    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
        assign wr[gi]  = upd_e && ctl_e && (idx_e == IDX_BITS'(gi));
        assign inv[gi] = upd_e && !ctl_e && bp.PredTakenE && (idx_e == IDX_BITS'(gi));

        sat_counter2 u_ctr (
            .clk      (CLK),
            .rst      (RST),
            .en       (wr[gi] && hit_e),
            .up       (bp.PCSrcE),
            .load     (wr[gi] && !hit_e),
            .load_val (bp.PCSrcE ? WT : WNT),
            .q        (ctr[gi])
        );
    end

    // Entry valid bits: allocate on control-flow resolve, drop on stale alias.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < ENTRIES; i++) valid[i] <= 1'b0;
        end else begin
            for (int i = 0; i < ENTRIES; i++) begin
                if (wr[i]) begin
                    valid[i] <= 1'b1;
                end else if (inv[i]) begin
                    valid[i] <= 1'b0;
                end
            end
        end
    end

    // Entry payload: tag/target/jump are refreshed on every resolve (hit or allocate).
    always_ff @(posedge CLK) begin
        for (int i = 0; i < ENTRIES; i++) begin
            if (wr[i]) begin
                tag_q[i] <= tag_e;
                tgt_q[i] <= bp.PCTargetE;
                jmp_q[i] <= bp.JumpE;
            end
        end
    end

    // Statistics counters, sticking at all-ones.
    always_ff @(posedge CLK) begin
        if (RST) begin
            br_count   <= '0;
            miss_count <= '0;
        end else if (upd_e) begin
            if (ctl_e && br_count != 32'hFFFF_FFFF) br_count <= br_count + 32'd1;
            if (mis_e && miss_count != 32'hFFFF_FFFF) miss_count <= miss_count + 32'd1;
        end
    end

    assign bp.BrCount   = br_count;
    assign bp.MissCount = miss_count;

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (IDX_BITS = 4).
module tb_branch_predictor;

    logic CLK = 1'b0;
    logic RST;
    int   n_chk  = 0;
    int   n_fail = 0;

    branch_predictor_if bif ();

    branch_predictor #(.IDX_BITS(4)) dut (
        .CLK (CLK),
        .RST (RST),
        .bp  (bif.slave)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive_e(input logic v, input logic br, input logic jmp, input logic src,
                           input logic [31:0] pc, input logic [31:0] tgt,
                           input logic ptk, input logic [31:0] ptgt);
        bif.ValidE      = v;
        bif.BranchE     = br;
        bif.JumpE       = jmp;
        bif.PCSrcE      = src;
        bif.PCE         = pc;
        bif.PCPlus4E    = pc + 32'd4;
        bif.PCTargetE   = tgt;
        bif.PredTakenE  = ptk;
        bif.PredTargetE = ptgt;
        #1;
    endtask

    task automatic idle();
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h4);
    endtask

    initial begin
        RST        = 1'b1;
        bif.StallE = 1'b0;
        bif.PCF    = 32'h100;
        idle();
        tick();
        tick();
        RST = 1'b0;
        #1;

        // Reset state
        chk("rst_predtaken", 32'(bif.PredTakenF), 32'd0);
        chk("rst_predtarget", bif.PredTargetF, 32'h104);
        chk("rst_brcount", bif.BrCount, 32'd0);
        chk("rst_misscount", bif.MissCount, 32'd0);
        chk("rst_ctr0", 32'(dut.ctr[0]), 32'd1);
        chk("bubble_nomis", 32'(bif.MispredictE), 32'd0);

        // Bubble carrying a stale prediction is ignored
        drive_e(1'b0, 1'b0, 1'b0, 1'b0, 32'h140, 32'h0, 1'b1, 32'h80);
        chk("bubble_stale_nomis", 32'(bif.MispredictE), 32'd0);
        chk("bubble_redirect", bif.RedirectPCE, 32'h144);

        // Taken branch at 0x100 -> 0x80, predicted not taken
        drive_e(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        chk("tk_mis", 32'(bif.MispredictE), 32'd1);
        chk("tk_redirect", bif.RedirectPCE, 32'h80);
        tick();
        idle();
        chk("tk_predtaken", 32'(bif.PredTakenF), 32'd1);
        chk("tk_predtarget", bif.PredTargetF, 32'h80);
        chk("tk_ctr", 32'(dut.ctr[0]), 32'd2);

        // Same branch not taken, predicted taken
        drive_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b1, 32'h80);
        chk("nt1_mis", 32'(bif.MispredictE), 32'd1);
        chk("nt1_redirect", bif.RedirectPCE, 32'h104);
        tick();
        idle();
        chk("nt1_ctr", 32'(dut.ctr[0]), 32'd1);
        chk("nt1_predtaken", 32'(bif.PredTakenF), 32'd0);
        chk("nt1_predtarget", bif.PredTargetF, 32'h104);

        // Not taken again, predicted not taken
        drive_e(1'b1, 1'b1, 1'b0, 1'b0, 32'h100, 32'h80, 1'b0, 32'h104);
        chk("nt2_mis", 32'(bif.MispredictE), 32'd0);
        chk("nt2_redirect", bif.RedirectPCE, 32'h104);
        tick();
        idle();
        chk("nt2_ctr", 32'(dut.ctr[0]), 32'd0);
        chk("nt2_misscount", bif.MissCount, 32'd2);
        chk("nt2_brcount", bif.BrCount, 32'd3);

        // Jump at 0x200 (same index as 0x100) allocated with target 0x300
        bif.PCF = 32'h200;
        drive_e(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h300, 1'b0, 32'h204);
        chk("jal_mis", 32'(bif.MispredictE), 32'd1);
        tick();
        idle();
        chk("jal_predtaken", 32'(bif.PredTakenF), 32'd1);
        chk("jal_predtarget", bif.PredTargetF, 32'h300);

        // jalr target changes to 0x340
        drive_e(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h340, 1'b1, 32'h300);
        chk("jalr_mis", 32'(bif.MispredictE), 32'd1);
        chk("jalr_redirect", bif.RedirectPCE, 32'h340);
        tick();
        idle();
        chk("jalr_predtarget", bif.PredTargetF, 32'h340);

        // jalr correctly predicted
        drive_e(1'b1, 1'b0, 1'b1, 1'b1, 32'h200, 32'h340, 1'b1, 32'h340);
        chk("jalr_ok_nomis", 32'(bif.MispredictE), 32'd0);
        tick();
        idle();
        chk("jalr_brcount", bif.BrCount, 32'd6);
        chk("jalr_misscount", bif.MissCount, 32'd4);

        // Stalled taken branch at 0x108 (idx 2), allocate on release
        bif.PCF    = 32'h108;
        bif.StallE = 1'b1;
        drive_e(1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 32'h40, 1'b0, 32'h10C);
        for (int i = 0; i < 3; i++) begin
            chk("stall1_mis_held", 32'(bif.MispredictE), 32'd1);
            tick();
            chk("stall1_brcount", bif.BrCount, 32'd6);
            chk("stall1_noalloc", 32'(bif.PredTakenF), 32'd0);
        end
        bif.StallE = 1'b0;
        #1;
        tick();
        idle();
        chk("stall1_brcount_rel", bif.BrCount, 32'd7);
        chk("stall1_misscount_rel", bif.MissCount, 32'd5);
        chk("stall1_ctr", 32'(dut.ctr[2]), 32'd2);
        chk("stall1_predtarget", bif.PredTargetF, 32'h40);

        // Stalled correctly predicted taken branch: counter moves one step
        bif.StallE = 1'b1;
        drive_e(1'b1, 1'b1, 1'b0, 1'b1, 32'h108, 32'h40, 1'b1, 32'h40);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall2_ctr_held", 32'(dut.ctr[2]), 32'd2);
        end
        chk("stall2_nomis", 32'(bif.MispredictE), 32'd0);
        bif.StallE = 1'b0;
        #1;
        tick();
        idle();
        chk("stall2_ctr", 32'(dut.ctr[2]), 32'd3);
        chk("stall2_brcount", bif.BrCount, 32'd8);

        // Alias: 0x100 owns index 0, 0x140 does not
        drive_e(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        tick();
        idle();
        bif.PCF = 32'h140;
        #1;
        chk("alias_nonowner_tk", 32'(bif.PredTakenF), 32'd0);
        chk("alias_nonowner_tgt", bif.PredTargetF, 32'h144);
        bif.PCF = 32'h100;
        #1;
        chk("alias_owner_tk", 32'(bif.PredTakenF), 32'd1);
        chk("alias_owner_tgt", bif.PredTargetF, 32'h80);

        // Stale prediction on an ALU op at 0x140
        drive_e(1'b1, 1'b0, 1'b0, 1'b0, 32'h140, 32'h999, 1'b1, 32'h80);
        chk("stale_mis", 32'(bif.MispredictE), 32'd1);
        chk("stale_redirect", bif.RedirectPCE, 32'h144);
        tick();
        idle();
        chk("stale_invalid", 32'(dut.valid[0]), 32'd0);
        chk("stale_predtaken", 32'(bif.PredTakenF), 32'd0);
        chk("stale_predtarget", bif.PredTargetF, 32'h104);
        chk("stale_brcount", bif.BrCount, 32'd9);
        chk("stale_misscount", bif.MissCount, 32'd7);

        // Reset overrides a same-cycle update
        drive_e(1'b1, 1'b1, 1'b0, 1'b1, 32'h100, 32'h80, 1'b0, 32'h104);
        RST = 1'b1;
        tick();
        RST = 1'b0;
        idle();
        chk("rst2_predtaken", 32'(bif.PredTakenF), 32'd0);
        chk("rst2_brcount", bif.BrCount, 32'd0);
        chk("rst2_misscount", bif.MissCount, 32'd0);
        chk("rst2_ctr0", 32'(dut.ctr[0]), 32'd1);
        chk("rst2_ctr2", 32'(dut.ctr[2]), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
